cuckoo_hash_table: RTL
======================

CUCKOO_HASH_TABLE -- requirements
Module: cuckoo_hash_table

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 8: key bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload bits.
REQ-003 SHALL have parameter NUMBER_OF_TABLES, default 3: ways, 2..8.
REQ-004 SHALL have parameter ADR_WIDTH, default 4: every table holds 2**ADR_WIDTH slots.
REQ-005 SHALL have parameter Q_MATRIX: per-table H3 matrix, ADR_WIDTH rows of KEY_WIDTH bits.
REQ-006 SHALL have parameter MAX_KICKS, default 16: eviction limit per insert.
REQ-007 SHALL have parameter OVERWRITE_EN, default 1: a write to a present key updates its data.
REQ-008 Ports SHALL be:
 clk  in  1  single clock, all logic rising-edge.
 reset  in  1  synchronous, active-high.
 valid_i  in  1  request valid.
 ready_o  out  1  request accepted when valid_i&&ready_o.
 op_i  in  2  00 NOP, 01 READ, 10 WRITE, 11 DELETE.
 key_i  in  KEY_WIDTH  request key.
 data_i  in  DATA_WIDTH  write payload.
 valid_o  out  1  response valid.
 ready_i  in  1  response consumer ready.
 status_o  out  3  0 OK, 1 NOT_FOUND, 2 KEY_PRESENT, 3 TABLE_FULL.
 key_o  out  KEY_WIDTH  response key (evicted key on TABLE_FULL).
 data_o  out  DATA_WIDTH  read data or evicted data.
 count_o  out  ADR_WIDTH+4  occupied slot count.

Function
REQ-009 Storage SHALL be per-table register arrays {valid, key, data}; reads combinational.
REQ-010 FSM states SHALL be IDLE, LOOKUP, KICK, RESP.
REQ-011 ready_o SHALL be 1 only in IDLE; an accepted NOP SHALL be consumed with no response.
REQ-012 Accepted READ/WRITE/DELETE SHALL register op/key/data and enter LOOKUP.
REQ-013 LOOKUP SHALL compare key against the valid slot at H3 address in every table in one cycle.
REQ-014 READ: hit -> OK with stored data; miss -> NOT_FOUND, data_o 0.
REQ-015 DELETE: hit -> clear valid, OK; miss -> NOT_FOUND.
REQ-016 WRITE hit: OVERWRITE_EN=1 -> update data, OK; else KEY_PRESENT, no change.
REQ-017 WRITE miss with a free slot SHALL write the lowest-index free table, OK.
REQ-018 WRITE miss with no free slot SHALL place the new entry in table 0, carry the victim, enter KICK.
REQ-019 KICK cycle SHALL target table (t+1) mod NUMBER_OF_TABLES, t = victim's origin table, at victim's hash; free -> store, OK; occupied -> swap, increment kick counter.
REQ-020 After MAX_KICKS swaps without success SHALL respond TABLE_FULL with the carried victim on key_o/data_o; no entry silently lost.
REQ-021 Response latency SHALL be 2 cycles from accept to valid_o for non-kick ops, plus one cycle per KICK.
REQ-022 In RESP, valid_o SHALL be 1 with outputs stable until ready_i; then IDLE.
REQ-023 count_o SHALL increment on successful new insert, decrement on successful delete, and remain unchanged on overwrite, swap and TABLE_FULL.

Reset
REQ-024 reset SHALL clear all valid bits, count_o, kick counter, and return FSM to IDLE within one cycle, aborting any operation.
REQ-025 During reset, valid_o=0, ready_o=0, status_o=0, key_o=0, data_o=0; ready_o=1 on the first cycle after reset deasserts.

Structure
REQ-026 Package cuckoo_pkg SHALL hold the op and status enums and the FSM state typedef.
REQ-027 Hashing SHALL instantiate h3_hash_function per table for the request key and per table for the carried victim key.

Verification
REQ-028 Reset then READ key 0x05 -> NOT_FOUND on cycle 2, count_o 0.
REQ-029 WRITE 0x05/0xAAAA_0001, READ 0x05 -> OK, data 0xAAAA_0001, count_o 1.
REQ-030 Identity Q in all tables, WRITE keys 0x03,0x13,0x23 -> tables 0,1,2 same slot, all OK; 4th key 0x33 -> kicks, MAX_KICKS=2 -> TABLE_FULL, victim on key_o, count_o 3.
REQ-031 OVERWRITE_EN=0, WRITE 0x05 twice -> second KEY_PRESENT, old data kept; DELETE 0x05 twice -> OK then NOT_FOUND.
REQ-032 Hold ready_i=0 for 5 cycles in RESP -> outputs stable, ready_o=0, no new accept.
REQ-033 Assert reset mid-KICK -> next cycle IDLE, count_o 0, all reads NOT_FOUND.

Source files
------------

// File: rtl/cuckoo_pkg.sv
// Shared types for the cuckoo hash table.
//   op_e     : request opcode carried on op_i
//   status_e : response code driven on status_o
//   state_e  : control FSM state encoding
package cuckoo_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_READ   = 2'b01,
        OP_WRITE  = 2'b10,
        OP_DELETE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        STS_OK          = 3'd0,
        STS_NOT_FOUND   = 3'd1,
        STS_KEY_PRESENT = 3'd2,
        STS_TABLE_FULL  = 3'd3
    } status_e;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOOKUP = 2'd1,
        FSM_KICK   = 2'd2,
        FSM_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/cuckoo_hash_table_if.sv
// Request/response bus of the cuckoo hash table.
//   request : valid_i, ready_o, op_i, key_i, data_i
//   response: valid_o, ready_i, status_o, key_o, data_o
//   status  : count_o (occupied slot count)
// slave = the table, master = the requester.
interface cuckoo_hash_table_if #(
    parameter int KEY_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 4
);
    logic                  valid_i;
    logic                  ready_o;
    logic [1:0]            op_i;
    logic [KEY_WIDTH-1:0]  key_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [2:0]            status_o;
    logic [KEY_WIDTH-1:0]  key_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [ADR_WIDTH+3:0]  count_o;

    modport slave (
        input  valid_i, op_i, key_i, data_i, ready_i,
        output ready_o, valid_o, status_o, key_o, data_o, count_o
    );

    modport master (
        output valid_i, op_i, key_i, data_i, ready_i,
        input  ready_o, valid_o, status_o, key_o, data_o, count_o
    );
endinterface

// File: rtl/h3_hash_function.sv
// H3 universal hash: address bit r is the parity of (key AND Q row r).
//   i_key  : key to hash
//   o_hash : slot address
module h3_hash_function #(
    parameter int KEY_WIDTH = 8,
    parameter int ADR_WIDTH = 4,
    parameter logic [ADR_WIDTH-1:0][KEY_WIDTH-1:0] Q = '0
)(
    input  logic [KEY_WIDTH-1:0] i_key,
    output logic [ADR_WIDTH-1:0] o_hash
);

    function automatic logic parity_f(input logic [KEY_WIDTH-1:0] i_v);
        return ^i_v;
    endfunction

    // One masked-parity per address bit.
    always_comb begin
        o_hash = '0;
        for (int r = 0; r < ADR_WIDTH; r++) begin
            o_hash[r] = parity_f(i_key & Q[r]);
        end
    end

endmodule

// File: rtl/cuckoo_hash_table.sv
// Multi-way cuckoo hash table with H3 hashing and bounded eviction chains.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts any operation
//   bus   : request/response bus (slave side), see cuckoo_hash_table_if
module cuckoo_hash_table
    import cuckoo_pkg::*;
#(
    parameter int KEY_WIDTH        = 8,
    parameter int DATA_WIDTH       = 32,
    parameter int NUMBER_OF_TABLES = 3,
    parameter int ADR_WIDTH        = 4,
    parameter logic [NUMBER_OF_TABLES-1:0][ADR_WIDTH-1:0][KEY_WIDTH-1:0] Q_MATRIX =
        96'h8D4B271E_5AC3963C_E1722D93,
    parameter int MAX_KICKS        = 16,
    parameter bit OVERWRITE_EN     = 1'b1
)(
    input logic          clk,
    input logic          reset,
    cuckoo_hash_table_if.slave bus
);

    localparam int SLOTS = 2 ** ADR_WIDTH;
    localparam int TW    = $clog2(NUMBER_OF_TABLES);
    localparam int KW    = $clog2(MAX_KICKS + 1);
    localparam int CW    = ADR_WIDTH + 4;
    localparam logic [TW-1:0] LAST_TBL  = TW'(NUMBER_OF_TABLES - 1);
    localparam logic [KW-1:0] KICK_ONE  = KW'(1);
    localparam logic [KW-1:0] KICK_LAST = KW'(MAX_KICKS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Storage
    logic                  r_tbl_valid [NUMBER_OF_TABLES][SLOTS];
    logic [KEY_WIDTH-1:0]  r_tbl_key   [NUMBER_OF_TABLES][SLOTS];
    logic [DATA_WIDTH-1:0] r_tbl_data  [NUMBER_OF_TABLES][SLOTS];

    // Control and datapath registers
    state_e                r_state, w_next_state;
    op_e                   r_op;
    logic [KEY_WIDTH-1:0]  r_key, r_vic_key, r_key_o;
    logic [DATA_WIDTH-1:0] r_data, r_vic_data, r_data_o;
    logic [TW-1:0]         r_vic_tbl;
    logic [KW-1:0]         r_kicks;
    logic [CW-1:0]         r_count;
    status_e               r_status;

    // Hash and lookup results
    logic [ADR_WIDTH-1:0]        w_hash_req [NUMBER_OF_TABLES];
    logic [ADR_WIDTH-1:0]        w_hash_vic [NUMBER_OF_TABLES];
    logic [NUMBER_OF_TABLES-1:0] w_hit, w_free;
    logic                        w_any_hit, w_any_free, w_kick_free;
    logic [TW-1:0]               w_hit_tbl, w_free_tbl, w_kick_tbl;
    logic [ADR_WIDTH-1:0]        w_hit_slot, w_free_slot, w_kick_slot;
    logic [KEY_WIDTH-1:0]        w_evict_key;
    logic [DATA_WIDTH-1:0]       w_evict_data;

    // Decisions
    logic                  w_wr_en, w_wr_valid;
    logic [TW-1:0]         w_wr_tbl;
    logic [ADR_WIDTH-1:0]  w_wr_slot;
    logic [KEY_WIDTH-1:0]  w_wr_key;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_resp_load, w_start_kick, w_swap, w_cnt_inc, w_cnt_dec;
    status_e               w_resp_status;
    logic [KEY_WIDTH-1:0]  w_resp_key;
    logic [DATA_WIDTH-1:0] w_resp_data;

    for (genvar g = 0; g < NUMBER_OF_TABLES; g++) begin : g_way
        h3_hash_function #(.KEY_WIDTH(KEY_WIDTH), .ADR_WIDTH(ADR_WIDTH), .Q(Q_MATRIX[g]))
            u_h3_req (.i_key(r_key), .o_hash(w_hash_req[g]));
        h3_hash_function #(.KEY_WIDTH(KEY_WIDTH), .ADR_WIDTH(ADR_WIDTH), .Q(Q_MATRIX[g]))
            u_h3_vic (.i_key(r_vic_key), .o_hash(w_hash_vic[g]));
        assign w_hit[g]  = r_tbl_valid[g][w_hash_req[g]] && (r_tbl_key[g][w_hash_req[g]] == r_key);
        assign w_free[g] = !r_tbl_valid[g][w_hash_req[g]];
    end

    // Lowest-index hit and free way; scanning downwards lets the lowest index win.
    always_comb begin
        w_any_hit  = 1'b0;
        w_any_free = 1'b0;
        w_hit_tbl  = '0;
        w_free_tbl = '0;
        for (int t = NUMBER_OF_TABLES - 1; t >= 0; t--) begin
            w_any_hit  = w_any_hit | w_hit[t];
            w_any_free = w_any_free | w_free[t];
            w_hit_tbl  = w_hit[t]  ? TW'(t) : w_hit_tbl;
            w_free_tbl = w_free[t] ? TW'(t) : w_free_tbl;
        end
    end

    assign w_hit_slot   = w_hash_req[w_hit_tbl];
    assign w_free_slot  = w_hash_req[w_free_tbl];
    // The carried victim always moves to the way after the one it was evicted from.
    assign w_kick_tbl   = (r_vic_tbl == LAST_TBL) ? '0 : r_vic_tbl + TW'(1);
    assign w_kick_slot  = w_hash_vic[w_kick_tbl];
    assign w_kick_free  = !r_tbl_valid[w_kick_tbl][w_kick_slot];
    assign w_evict_key  = r_tbl_key[w_kick_tbl][w_kick_slot];
    assign w_evict_data = r_tbl_data[w_kick_tbl][w_kick_slot];

    // Operation decision: single table write port plus response/counter updates.
    always_comb begin
        w_wr_en       = 1'b0;
        w_wr_valid    = 1'b1;
        w_wr_tbl      = '0;
        w_wr_slot     = '0;
        w_wr_key      = r_key;
        w_wr_data     = r_data;
        w_resp_load   = 1'b0;
        w_resp_status = STS_OK;
        w_resp_key    = r_key;
        w_resp_data   = '0;
        w_start_kick  = 1'b0;
        w_swap        = 1'b0;
        w_cnt_inc     = 1'b0;
        w_cnt_dec     = 1'b0;
        case (r_state)
            FSM_LOOKUP: begin
                case (r_op)
                    OP_READ: begin
                        w_resp_load = 1'b1;
                        if (w_any_hit) begin
                            w_resp_data = r_tbl_data[w_hit_tbl][w_hit_slot];
                        end else begin
                            w_resp_status = STS_NOT_FOUND;
                        end
                    end
                    OP_DELETE: begin
                        w_resp_load = 1'b1;
                        if (w_any_hit) begin
                            w_wr_en    = 1'b1;
                            w_wr_valid = 1'b0;
                            w_wr_tbl   = w_hit_tbl;
                            w_wr_slot  = w_hit_slot;
                            w_cnt_dec  = 1'b1;
                        end else begin
                            w_resp_status = STS_NOT_FOUND;
                        end
                    end
                    OP_WRITE: begin
                        if (w_any_hit) begin
                            w_resp_load = 1'b1;
                            if (OVERWRITE_EN) begin
                                w_wr_en   = 1'b1;
                                w_wr_tbl  = w_hit_tbl;
                                w_wr_slot = w_hit_slot;
                            end else begin
                                w_resp_status = STS_KEY_PRESENT;
                            end
                        end else if (w_any_free) begin
                            w_resp_load = 1'b1;
                            w_wr_en     = 1'b1;
                            w_wr_tbl    = w_free_tbl;
                            w_wr_slot   = w_free_slot;
                            w_cnt_inc   = 1'b1;
                        end else begin
                            // New entry takes way 0; its old occupant becomes the victim.
                            w_wr_en      = 1'b1;
                            w_wr_slot    = w_hash_req[0];
                            w_start_kick = 1'b1;
                        end
                    end
                    default: begin
                        w_resp_load = 1'b0;
                    end
                endcase
            end
            FSM_KICK: begin
                w_wr_en   = 1'b1;
                w_wr_tbl  = w_kick_tbl;
                w_wr_slot = w_kick_slot;
                w_wr_key  = r_vic_key;
                w_wr_data = r_vic_data;
                if (w_kick_free) begin
                    w_resp_load = 1'b1;
                    w_cnt_inc   = 1'b1;
                end else begin
                    w_swap = 1'b1;
                    if (r_kicks == KICK_LAST) begin
                        // Chain exhausted: hand the displaced entry back instead of dropping it.
                        w_resp_load   = 1'b1;
                        w_resp_status = STS_TABLE_FULL;
                        w_resp_key    = w_evict_key;
                        w_resp_data   = w_evict_data;
                    end else begin
                        w_resp_load = 1'b0;
                    end
                end
            end
            default: begin
                w_resp_load = 1'b0;
            end
        endcase
    end

    // Table storage; only the valid bits need clearing on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    r_tbl_valid[t][s] <= 1'b0;
                end
            end
        end else if (w_wr_en) begin
            r_tbl_valid[w_wr_tbl][w_wr_slot] <= w_wr_valid;
            r_tbl_key[w_wr_tbl][w_wr_slot]   <= w_wr_key;
            r_tbl_data[w_wr_tbl][w_wr_slot]  <= w_wr_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FSM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a NOP is accepted in IDLE and simply dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FSM_IDLE:   w_next_state = (bus.valid_i && (bus.op_i != OP_NOP)) ? FSM_LOOKUP : FSM_IDLE;
            FSM_LOOKUP: w_next_state = w_start_kick ? FSM_KICK : FSM_RESP;
            FSM_KICK:   w_next_state = w_resp_load ? FSM_RESP : FSM_KICK;
            FSM_RESP:   w_next_state = bus.ready_i ? FSM_IDLE : FSM_RESP;
            default:    w_next_state = FSM_IDLE;
        endcase
    end

    // Request capture, victim tracking, occupancy count and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= OP_NOP;
            r_key      <= '0;
            r_data     <= '0;
            r_vic_key  <= '0;
            r_vic_data <= '0;
            r_vic_tbl  <= '0;
            r_kicks    <= '0;
            r_count    <= '0;
            r_status   <= STS_OK;
            r_key_o    <= '0;
            r_data_o   <= '0;
        end else begin
            if ((r_state == FSM_IDLE) && bus.valid_i) begin
                r_op   <= op_e'(bus.op_i);
                r_key  <= bus.key_i;
                r_data <= bus.data_i;
            end
            if (w_start_kick) begin
                r_vic_key  <= r_tbl_key[0][w_hash_req[0]];
                r_vic_data <= r_tbl_data[0][w_hash_req[0]];
                r_vic_tbl  <= '0;
                r_kicks    <= '0;
            end else if (w_swap) begin
                r_vic_key  <= w_evict_key;
                r_vic_data <= w_evict_data;
                r_vic_tbl  <= w_kick_tbl;
                r_kicks    <= r_kicks + KICK_ONE;
            end
            if (w_cnt_inc) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_cnt_dec) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_resp_load) begin
                r_status <= w_resp_status;
                r_key_o  <= w_resp_key;
                r_data_o <= w_resp_data;
            end
        end
    end

    // FSM outputs; everything reads zero while reset is held.
    always_comb begin
        bus.count_o = r_count;
        if (reset) begin
            bus.ready_o  = 1'b0;
            bus.valid_o  = 1'b0;
            bus.status_o = 3'd0;
            bus.key_o    = '0;
            bus.data_o   = '0;
        end else begin
            bus.ready_o  = (r_state == FSM_IDLE);
            bus.valid_o  = (r_state == FSM_RESP);
            bus.status_o = r_status;
            bus.key_o    = r_key_o;
            bus.data_o   = r_data_o;
        end
    end

endmodule
